// File: rtl/shift_sequencer.sv
// Multi-cycle shift unit: one single-bit shift step per clock in one of four
// modes, with a BUSY/DONE handshake for the control unit to stall on.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       dir_i,
  input  logic [AMT_W-1:0] amount_i,
  input  logic [WIDTH-1:0] input_i,
  output logic [WIDTH-1:0] output_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DONE_S = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] stepped;

  // Single-bit step of the working register, selected by the latched mode.
  always_comb begin
    stepped = work_q;
    unique case (mode_q)
      MODE_LSL: stepped = {work_q[WIDTH-2:0], 1'b0};
      MODE_LSR: stepped = {1'b0, work_q[WIDTH-1:1]};
      MODE_ASR: stepped = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      MODE_ROL: stepped = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
      default:  stepped = work_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    result_d = result_q;

    unique case (state_q)
      IDLE, DONE_S: begin
        if (start_i) begin
          work_d = input_i;
          cnt_d  = amount_i;
          mode_d = dir_i;
          // A zero amount bypasses SHIFT and publishes the operand directly.
          if (amount_i == '0) begin
            result_d = input_i;
            state_d  = DONE_S;
          end else begin
            state_d  = SHIFT;
          end
        end else if (state_q == DONE_S) begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
        work_d = stepped;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          result_d = stepped;
          state_d  = DONE_S;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      work_q   <= '0;
      cnt_q    <= '0;
      mode_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      result_q <= result_d;
    end
  end

  assign output_o = result_q;
  assign busy_o   = (state_q == SHIFT);
  assign done_o   = (state_q == DONE_S);

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle shift unit for the 16-bit ALU datapath. It applies one single-bit shift step per clock, the same step as the ALU's 1-bit left shifter, extended to four modes. A 16-bit operand is shifted by a 4-bit amount (0–15). The block sits between the register-file operand bus and the ALU result mux, and reports completion with a BUSY/DONE handshake so the control unit can stall.

## Interface
Parameters:
- WIDTH, 16, operand/result width
- AMT_W, 4, shift-amount width; maximum amount is 2^AMT_W − 1

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- START  in  1  request; sampled only in IDLE or DONE_S
- DIR  in  2  mode: 00 logical left, 01 logical right, 10 arithmetic right, 11 rotate left
- AMOUNT  in  AMT_W  shift count, unsigned
- INPUT  in  WIDTH  operand
- OUTPUT  out  WIDTH  registered result
- BUSY  out  1  high while in SHIFT
- DONE  out  1  one-cycle pulse; high exactly while in DONE_S

## Operation
- Internal registers:
  - work (WIDTH)
  - cnt (AMT_W)
  - mode (2)
  - state: IDLE, SHIFT, DONE_S
- Request acceptance: START=1 in IDLE or DONE_S. On that edge:
  - work←INPUT, cnt←AMOUNT, mode←DIR
  - if AMOUNT=0: next state is DONE_S and OUTPUT←INPUT
  - otherwise: next state is SHIFT
- One step per edge in SHIFT:
  - 00: work←{work[W-2:0],0}
  - 01: work←{0,work[W-1:1]}
  - 10: work←{work[W-1],work[W-1:1]}
  - 11: work←{work[W-2:0],work[W-1]}
- Every SHIFT edge also does cnt←cnt−1.
  - When cnt=1 at that edge: OUTPUT←stepped value, next state DONE_S.
  - Otherwise the block stays in SHIFT.
- DONE_S:
  - with START=1, a new request is accepted (back-to-back)
  - otherwise the next state is IDLE
- START in SHIFT is ignored. The in-flight operation and its inputs are unaffected.
- INPUT, DIR and AMOUNT are don't-care except on the accepting edge.
- OUTPUT changes only when entering DONE_S. It holds its value through IDLE and through subsequent SHIFT cycles. Intermediate values never appear on OUTPUT.
- Bits shifted out are discarded. There is no carry or overflow output.
- RST at any time forces the following immediately, regardless of CLK:
  - state=IDLE
  - work=0, cnt=0, mode=0
  - OUTPUT=0, BUSY=0, DONE=0
- RST aborts any operation in flight, with no DONE pulse.

## Timing
- Reset values: OUTPUT=0, BUSY=0, DONE=0, state IDLE.
- Let E0 be the edge on which START is accepted, and N = AMOUNT.
  - N=0: DONE high during the cycle after E0; OUTPUT=INPUT from E0; BUSY never rises.
  - N≥1: BUSY high from E0 to E_N (N cycles); shifts happen on E1…E_N; DONE high and OUTPUT valid in the cycle after E_N.
- Latency from accept to DONE is N+1 edges (E0…E_N), giving throughput of one result per N+1 cycles with back-to-back START.
- BUSY and DONE are never high together.
- DONE is high for exactly one cycle per accepted request.
- Both BUSY and DONE are decoded from the state register, with no combinational path from inputs.
- Maximum latency is 15 shift edges (N=15), then DONE.
- Deasserting RST has no effect until the first clock edge; the first accept can occur on that edge.

## Test plan
- Reset: assert RST for 20 ns mid-operation (after 0x00FF, DIR=00, N=8 has run 3 edges). Required response: OUTPUT=0, BUSY=0, DONE=0 immediately; no DONE pulse follows; the next request completes normally.
- Logical left: INPUT=100, DIR=00, N=1 → 200. INPUT=0xFFFF, N=1 → 0xFFFE. In both cases DONE is high in the cycle after E1, with BUSY high for 1 cycle.
- Right shifts:
  - INPUT=0x8000, DIR=01, N=15 → 0x0001
  - DIR=10, N=15 → 0xFFFF
  - INPUT=0x7FF0, DIR=10, N=4 → 0x07FF
  - In every case BUSY is high for exactly N cycles.
- Rotate and zero amount:
  - INPUT=0x8001, DIR=11, N=4 → 0x0018
  - INPUT=0x1234, any DIR, N=0 → 0x1234, with DONE in the cycle after E0 and BUSY never high
- Handshake:
  - START pulsed again in SHIFT with different INPUT is ignored; the result matches the first request.
  - START held high through DONE_S starts a second request (INPUT=3, DIR=00, N=2 → 12) with no IDLE cycle in between.
  - OUTPUT holds the first result until the second DONE.
